ultrasonic_scheduler: RTL
=========================

Name: ultrasonic_scheduler

Overview:
Round-robin sequencer for the robot's three HC-SR04-style ultrasonic sensors. Fires one trigger at a time to avoid acoustic crosstalk, times each echo with a single shared width counter, and compares the width against a distance threshold. Publishes an atomically updated 3-bit obstacle vector once per sweep for the motor-direction logic.

Parameters:
TRIG_CYCLES, 500, trigger pulse length in clocks (10 us at 50 MHz)
TIMEOUT_CYCLES, 1500000, maximum wait for echo rise and maximum echo width (30 ms)
THRESH_CYCLES, 58000, echo width below which a sensor reports an obstacle (~20 cm)
GUARD_CYCLES, 500000, quiet gap between sensors (10 ms)
CNT_W, 21, shared counter width; must hold TIMEOUT_CYCLES

Ports:
fpgaclk  in  1  system clock
rst  in  1  asynchronous active-high reset
enable  in  1  run sweeps while high
echo  in  3  raw echo inputs, bit i = sensor i
trigger  out  3  trigger outputs, at most one bit high at any time
obstacle  out  3  registered obstacle vector, bit i = 1 means object nearer than threshold
sweep_done  out  1  one-cycle pulse when obstacle is updated
timeout_flag  out  3  bit i = 1 if sensor i timed out in the last sweep
last_width  out  CNT_W  echo width of the most recently measured sensor (0 on timeout)
busy  out  1  high whenever FSM is not IDLE

Behaviour:
- Reset (async, rst=1): FSM=IDLE, idx=0, counter=0, all outputs 0, shadow registers 0, echo synchronizers 0.
- Echo is passed through a 2-flop synchronizer per bit; all decisions use the synchronized value esync. This adds a fixed 2-cycle latency and does not bias widths.
- States:
  - IDLE: busy=0. If enable=1, go to TRIG with counter cleared.
  - TRIG: trigger[idx]=1 for exactly TRIG_CYCLES cycles, then go to WAIT_RISE with counter cleared.
  - WAIT_RISE: wait for a 0->1 transition of esync[idx]. On rise, go to MEASURE with counter=1. If the counter reaches TIMEOUT_CYCLES first: shadow_obst[idx]=0, shadow_to[idx]=1, last_width=0, go to GUARD.
  - MEASURE: counter increments while esync[idx]=1. On fall: last_width=counter, shadow_obst[idx]=(counter<THRESH_CYCLES), shadow_to[idx]=0, go to GUARD. If the counter reaches TIMEOUT_CYCLES: treat as a timeout (same actions as WAIT_RISE timeout).
  - GUARD: wait GUARD_CYCLES cycles. If idx<2: idx++, go to TRIG. If idx==2: in the same cycle, obstacle<=shadow_obst and timeout_flag<=shadow_to, pulse sweep_done, idx=0. Then go to TRIG if enable=1, else IDLE.
- Counter saturates at TIMEOUT_CYCLES; it never wraps.
- enable is sampled only in IDLE and at the end of the idx==2 GUARD. A sweep in progress always completes.
- Echo activity on non-selected sensors is ignored.
- A width exactly equal to THRESH_CYCLES is not an obstacle.
- Only obstacle, timeout_flag and sweep_done change at sweep end. last_width updates per sensor.
- rst asserted mid-sweep: immediate return to reset state. trigger drops asynchronously and the partial sweep is discarded.

Optional Feature:
Macro OBSTACLE_HYST_EN.
- Defined: each obstacle bit changes only when the same new value is computed in two consecutive sweeps. A per-bit pending register (reset 0) holds the candidate value. sweep_done still pulses every sweep. timeout_flag is unfiltered.
- Undefined: obstacle is loaded directly from the shadow register every sweep.

Test Plan:
All scenarios use TRIG_CYCLES=4, TIMEOUT_CYCLES=200, THRESH_CYCLES=50, GUARD_CYCLES=10.
1. Echoes of 30/80/120 cycles on sensors 0/1/2 -> obstacle=3'b001, timeout_flag=0, one sweep_done pulse, last_width=120; each trigger bit high for exactly 4 cycles, in order 0,1,2, never overlapping.
2. No echo on sensor 1 -> sensor 1 WAIT_RISE lasts 200 cycles; timeout_flag=3'b010, obstacle[1]=0, last_width=0 after sensor 1.
3. Echoes of exactly 49 and exactly 50 cycles -> obstacle bit 1 and 0 respectively.
4. Sensor 2 echo stuck high for 500 cycles -> measurement aborted at 200, timeout_flag[2]=1, FSM recovers and the next sweep starts normally.
5. enable dropped during sensor 0 of a sweep -> sweep completes, sweep_done pulses, FSM returns to IDLE with busy=0; rst pulsed mid-MEASURE -> trigger=0, obstacle=0, state IDLE in the same cycle.
6. With OBSTACLE_HYST_EN: sensor 0 toggles near/far on alternate sweeps -> obstacle[0] stays 0; two consecutive near sweeps -> obstacle[0]=1 at the second sweep_done.

Source files
------------

// File: rtl/ultrasonic_scheduler_if.sv
// Sensor-side bundle for ultrasonic_scheduler: enable, raw echoes, triggers and sweep results.
interface ultrasonic_scheduler_if #(
    parameter int unsigned CNT_W = 21
);
    logic             enable;
    logic [2:0]       echo;
    logic [2:0]       trigger;
    logic [2:0]       obstacle;
    logic             sweep_done;
    logic [2:0]       timeout_flag;
    logic [CNT_W-1:0] last_width;
    logic             busy;

    modport slave (
        input  enable, echo,
        output trigger, obstacle, sweep_done, timeout_flag, last_width, busy
    );

    modport master (
        output enable, echo,
        input  trigger, obstacle, sweep_done, timeout_flag, last_width, busy
    );
endinterface

// File: rtl/ultrasonic_scheduler.sv
// Round-robin trigger/echo sequencer for three ultrasonic sensors with a shared width counter.
// Optional macro OBSTACLE_HYST_EN: obstacle bits change only after two consecutive agreeing sweeps.
module ultrasonic_scheduler #(
    parameter int unsigned TRIG_CYCLES    = 500,
    parameter int unsigned TIMEOUT_CYCLES = 1500000,
    parameter int unsigned THRESH_CYCLES  = 58000,
    parameter int unsigned GUARD_CYCLES   = 500000,
    parameter int unsigned CNT_W          = 21
) (
    input  logic                   fpgaclk,
    input  logic                   rst,
    ultrasonic_scheduler_if.slave  bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_TRIG  = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_MEAS  = 3'd3;
    localparam logic [2:0] S_GUARD = 3'd4;

    localparam logic [CNT_W-1:0] L_TRIG_LAST  = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] L_TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] L_TO         = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] L_THRESH     = CNT_W'(THRESH_CYCLES);
    localparam logic [CNT_W-1:0] L_GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] L_ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0] L_ZERO       = CNT_W'(0);

    function automatic logic sel_bit(input logic [2:0] v, input logic [1:0] i);
        case (i)
            2'd0:    sel_bit = v[0];
            2'd1:    sel_bit = v[1];
            2'd2:    sel_bit = v[2];
            default: sel_bit = 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] onehot(input logic [1:0] i);
        case (i)
            2'd0:    onehot = 3'b001;
            2'd1:    onehot = 3'b010;
            2'd2:    onehot = 3'b100;
            default: onehot = 3'b000;
        endcase
    endfunction

    logic [2:0]       r_state;
    logic [1:0]       r_idx;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_esync1;
    logic [2:0]       r_esync2;
    logic [2:0]       r_esync_d;
    logic [2:0]       r_trigger;
    logic [2:0]       r_obst;
    logic [2:0]       r_to_flag;
    logic             r_sweep_done;
    logic [CNT_W-1:0] r_last_width;
    logic             r_busy;
    logic [2:0]       r_shadow_obst;
    logic [2:0]       r_shadow_to;

    logic             w_sel_echo;
    logic             w_rise;
    logic [2:0]       w_sel_mask;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [2:0]       w_obst_next;

    assign w_sel_echo = sel_bit(r_esync2, r_idx);
    assign w_rise     = w_sel_echo & ~sel_bit(r_esync_d, r_idx);
    assign w_sel_mask = onehot(r_idx);
    assign w_cnt_inc  = (r_cnt >= L_TO) ? L_TO : (r_cnt + L_ONE);

`ifdef OBSTACLE_HYST_EN
    logic [2:0] r_pend;
    // A bit follows the shadow only when the pending candidate already agreed last sweep.
    assign w_obst_next = (r_shadow_obst & ~(r_shadow_obst ^ r_pend)) |
                         (r_obst & (r_shadow_obst ^ r_pend));
`else
    assign w_obst_next = r_shadow_obst;
`endif

    // Echo synchronizer plus one extra stage for rise detection.
    always_ff @(posedge fpgaclk or posedge rst) begin
        if (rst) begin
            r_esync1  <= 3'b000;
            r_esync2  <= 3'b000;
            r_esync_d <= 3'b000;
        end else begin
            r_esync1  <= bus.echo;
            r_esync2  <= r_esync1;
            r_esync_d <= r_esync2;
        end
    end

    // Sequencer: trigger, wait for echo, measure, guard gap, publish at end of sweep.
    always_ff @(posedge fpgaclk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_idx         <= 2'd0;
            r_cnt         <= L_ZERO;
            r_trigger     <= 3'b000;
            r_obst        <= 3'b000;
            r_to_flag     <= 3'b000;
            r_sweep_done  <= 1'b0;
            r_last_width  <= L_ZERO;
            r_busy        <= 1'b0;
            r_shadow_obst <= 3'b000;
            r_shadow_to   <= 3'b000;
`ifdef OBSTACLE_HYST_EN
            r_pend        <= 3'b000;
`endif
        end else begin
            r_sweep_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.enable) begin
                        r_state   <= S_TRIG;
                        r_cnt     <= L_ZERO;
                        r_trigger <= onehot(r_idx);
                        r_busy    <= 1'b1;
                    end
                end
                S_TRIG: begin
                    if (r_cnt == L_TRIG_LAST) begin
                        r_state   <= S_WAIT;
                        r_cnt     <= L_ZERO;
                        r_trigger <= 3'b000;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_WAIT: begin
                    if (w_rise) begin
                        r_state <= S_MEAS;
                        r_cnt   <= L_ONE;
                    end else if (r_cnt >= L_TO_LAST) begin
                        r_state       <= S_GUARD;
                        r_cnt         <= L_ZERO;
                        r_last_width  <= L_ZERO;
                        r_shadow_obst <= r_shadow_obst & ~w_sel_mask;
                        r_shadow_to   <= r_shadow_to | w_sel_mask;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_MEAS: begin
                    if (!w_sel_echo) begin
                        r_state       <= S_GUARD;
                        r_cnt         <= L_ZERO;
                        r_last_width  <= r_cnt;
                        r_shadow_obst <= (r_shadow_obst & ~w_sel_mask) |
                                         (w_sel_mask & {3{r_cnt < L_THRESH}});
                        r_shadow_to   <= r_shadow_to & ~w_sel_mask;
                    end else if (r_cnt >= L_TO_LAST) begin
                        // Echo still high as the count hits the limit: same handling as no echo.
                        r_state       <= S_GUARD;
                        r_cnt         <= L_ZERO;
                        r_last_width  <= L_ZERO;
                        r_shadow_obst <= r_shadow_obst & ~w_sel_mask;
                        r_shadow_to   <= r_shadow_to | w_sel_mask;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_GUARD: begin
                    if (r_cnt == L_GUARD_LAST) begin
                        r_cnt <= L_ZERO;
                        if (r_idx == 2'd2) begin
                            r_idx        <= 2'd0;
                            r_obst       <= w_obst_next;
                            r_to_flag    <= r_shadow_to;
                            r_sweep_done <= 1'b1;
`ifdef OBSTACLE_HYST_EN
                            r_pend       <= r_shadow_obst;
`endif
                            if (bus.enable) begin
                                r_state   <= S_TRIG;
                                r_trigger <= 3'b001;
                            end else begin
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_idx     <= r_idx + 2'd1;
                            r_state   <= S_TRIG;
                            r_trigger <= onehot(r_idx + 2'd1);
                        end
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_idx     <= 2'd0;
                    r_cnt     <= L_ZERO;
                    r_trigger <= 3'b000;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.trigger      = r_trigger;
    assign bus.obstacle     = r_obst;
    assign bus.sweep_done   = r_sweep_done;
    assign bus.timeout_flag = r_to_flag;
    assign bus.last_width   = r_last_width;
    assign bus.busy         = r_busy;
endmodule
